// File: rtl/cs_periph_resp.sv
`default_nettype none
// ============================================================================
// cs_periph_resp : chip-select bus responder, 8-byte window with wait states.
// Optional ERR output when CS_PERIPH_ERR_EN is defined.  Rev 1.0
// ============================================================================
module cs_periph_resp #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  RST_PORT    = 8'h00
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CS_N,
  input  logic [2:0] ADDR,
  input  logic       RD_N,
  input  logic       WR_N,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOUT_OE,
  output logic       RDY,
  input  logic [7:0] PORT_IN,
`ifdef CS_PERIPH_ERR_EN
  output logic       ERR,
`endif
  output logic [7:0] PORT_OUT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] regs_q [0:6];
  logic [7:0] regs_d [0:6];
  logic [7:0] dout_q, dout_d;
  logic       dout_oe_q, dout_oe_d;
  logic       rdy_q, rdy_d;
  logic [7:0] rd_win [0:7];

  logic w_req;
  logic w_released;

  assign w_req      = !CS_N && (RD_N ^ WR_N);
  // Release is judged against the strobe that was latched, not whichever is low now.
  assign w_released = CS_N || (is_wr_q ? WR_N : RD_N);

  always_comb begin
    for (int i = 0; i < 7; i++) rd_win[i] = regs_q[i];
    rd_win[7] = PORT_IN;
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 3'd0;
      din_q   <= 8'h00;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    is_wr_d = is_wr_q;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          addr_d  = ADDR;
          din_d   = DIN;
          is_wr_d = !WR_N;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_released)          state_d = S_IDLE;
        else if (cnt_q == 4'd0)  state_d = S_ACK;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  if (w_released) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic, all of it registered below
  always_comb begin
    for (int i = 0; i < 7; i++) regs_d[i] = regs_q[i];
    dout_d    = dout_q;
    dout_oe_d = dout_oe_q;
    rdy_d     = 1'b0;
    case (state_q)
      S_ACK: begin
        rdy_d = 1'b1;
        if (is_wr_q) begin
          for (int i = 0; i < 7; i++)
            if (addr_q == 3'(i)) regs_d[i] = din_q;
        end else begin
          dout_d    = rd_win[addr_q];
          dout_oe_d = 1'b1;
        end
      end
      S_HOLD:  if (w_released) dout_oe_d = 1'b0;
      default: dout_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs_q[0] <= RST_PORT;
      for (int i = 1; i < 7; i++) regs_q[i] <= 8'h00;
      dout_q    <= 8'h00;
      dout_oe_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) regs_q[i] <= regs_d[i];
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef CS_PERIPH_ERR_EN
  logic err_q, err_d;
  logic w_illegal;
  logic w_abort;

  assign w_illegal = (state_q == S_IDLE) && !CS_N && !RD_N && !WR_N;
  assign w_abort   = (state_q == S_WAIT) && w_released;

  // Set wins over the clear from a completing write.
  always_comb begin
    err_d = err_q;
    if (state_q == S_ACK && is_wr_q) err_d = 1'b0;
    if (w_illegal || w_abort)        err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign ERR = err_q;
`endif

  assign DOUT     = dout_q;
  assign DOUT_OE  = dout_oe_q;
  assign RDY      = rdy_q;
  assign PORT_OUT = regs_q[0];

endmodule
`default_nettype wire

// File: tb/tb_cs_periph_resp.sv
`default_nettype none
// ============================================================================
// tb_cs_periph_resp : randomized bench with a transaction-level model of the
// responder, compared every cycle, plus literal pins.  Rev 1.0
// ============================================================================
module tb_cs_periph_resp;

  localparam int unsigned WS    = 2;
  localparam logic [7:0]  RSTPV = 8'h5A;

  logic       CLK = 1'b0;
  logic       RST_N, CS_N, RD_N, WR_N;
  logic [2:0] ADDR;
  logic [7:0] DIN, DOUT, PORT_IN, PORT_OUT;
  logic       DOUT_OE, RDY;
`ifdef CS_PERIPH_ERR_EN
  logic       ERR;
`endif

  cs_periph_resp #(.WAIT_STATES(WS), .RST_PORT(RSTPV)) dut (
    .CLK(CLK), .RST_N(RST_N), .CS_N(CS_N), .ADDR(ADDR), .RD_N(RD_N), .WR_N(WR_N),
    .DIN(DIN), .DOUT(DOUT), .DOUT_OE(DOUT_OE), .RDY(RDY), .PORT_IN(PORT_IN),
`ifdef CS_PERIPH_ERR_EN
    .ERR(ERR),
`endif
    .PORT_OUT(PORT_OUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an access is a number of edges since acceptance.
  logic [7:0] mem [0:7];
  bit         m_pend, m_hold, m_wr;
  int         m_acc, edge_cnt;
  logic [2:0] m_addr;
  logic [7:0] m_din;
  logic [7:0] exp_dout;
  bit         exp_rdy, exp_oe, exp_err;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      mem[0] = RSTPV;
      m_pend = 0; m_hold = 0; m_wr = 0;
      exp_dout = 8'h00; exp_rdy = 0; exp_oe = 0; exp_err = 0;
      edge_cnt = 0; m_acc = 0;
    end else begin
      bit released;
      int k;
      edge_cnt++;
      released = CS_N || (m_wr ? WR_N : RD_N);
      exp_rdy = 0;
      if (m_pend) begin
        k = edge_cnt - m_acc;
        if (k <= int'(WS) && released) begin
          m_pend  = 0;
          exp_err = 1;
        end else if (k == int'(WS) + 1) begin
          m_pend  = 0;
          m_hold  = 1;
          exp_rdy = 1;
          if (m_wr) begin
            if (m_addr != 3'd7) mem[m_addr] = m_din;
            exp_err = 0;
          end else begin
            exp_dout = (m_addr == 3'd7) ? PORT_IN : mem[m_addr];
            exp_oe   = 1;
          end
        end
      end else if (m_hold) begin
        if (released) begin
          m_hold = 0;
          exp_oe = 0;
        end
      end else if (!CS_N && !RD_N && !WR_N) begin
        exp_err = 1;
      end else if (!CS_N && (RD_N != WR_N)) begin
        m_pend = 1; m_acc = edge_cnt;
        m_wr = !WR_N; m_addr = ADDR; m_din = DIN;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("rdy", RDY, exp_rdy);
      check("dout", DOUT, exp_dout);
      check("dout_oe", DOUT_OE, exp_oe);
      check("port_out", PORT_OUT, mem[0]);
`ifdef CS_PERIPH_ERR_EN
      check("err", ERR, exp_err);
`endif
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic access(input bit wr, input logic [2:0] a, input logic [7:0] d,
                        input int hold_extra, output logic [7:0] rd, output int lat);
    bit got;
    CS_N = 0; ADDR = a; DIN = d; RD_N = wr; WR_N = !wr;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (RDY) got = 1;
      else begin
        ADDR = 3'($urandom);
        DIN  = 8'($urandom);
      end
    end
    if (!got) check("rdy_timeout", 32'd0, 32'd1);
    rd = DOUT;
    repeat (hold_extra) tick();
    CS_N = 1; RD_N = 1; WR_N = 1;
    tick();
  endtask

  logic [7:0] rd;
  int lat;

  initial begin
    CS_N = 1; RD_N = 1; WR_N = 1; ADDR = 0; DIN = 0; PORT_IN = 0; RST_N = 1;
    #2 RST_N = 0;
    chk_en = 1;
    repeat (3) tick();
    check("rst_dout", DOUT, 8'h00);
    check("rst_oe", DOUT_OE, 0);
    check("rst_rdy", RDY, 0);
    check("rst_port", PORT_OUT, 8'h5A);
    RST_N = 1;
    tick();

    access(1, 3'd3, 8'hA5, 0, rd, lat);
    check("wr_latency", lat, 4);
    access(0, 3'd3, 8'h00, 3, rd, lat);
    check("rd3_data", rd, 8'hA5);
    check("rd_latency", lat, 4);

    access(1, 3'd0, 8'h3C, 1, rd, lat);
    check("port_out_3c", PORT_OUT, 8'h3C);

    PORT_IN = 8'h81;
    access(0, 3'd7, 8'h00, 0, rd, lat);
    check("rd7_a", rd, 8'h81);
    access(1, 3'd7, 8'hFF, 0, rd, lat);
    check("wr7_rdy_latency", lat, 4);
    access(0, 3'd7, 8'h00, 0, rd, lat);
    check("rd7_b", rd, 8'h81);

    CS_N = 0; RD_N = 0; WR_N = 0;
    repeat (3) tick();
`ifdef CS_PERIPH_ERR_EN
    check("err_set", ERR, 1);
`endif
    CS_N = 1; RD_N = 1; WR_N = 1;
    tick();
    access(0, 3'd3, 8'h00, 0, rd, lat);
    check("rd3_after_illegal", rd, 8'hA5);
    access(1, 3'd2, 8'h11, 0, rd, lat);
`ifdef CS_PERIPH_ERR_EN
    check("err_clear", ERR, 0);
`endif

    CS_N = 0; WR_N = 0; RD_N = 1; ADDR = 3'd2; DIN = 8'h77;
    tick();
    WR_N = 1;
    CS_N = 1;
    repeat (3) tick();
    access(0, 3'd2, 8'h00, 0, rd, lat);
    check("rd2_after_abort", rd, 8'h11);
    check("post_abort_latency", lat, 4);

    access(1, 3'd4, 8'h99, 0, rd, lat);
    CS_N = 0; WR_N = 0; RD_N = 1; ADDR = 3'd4; DIN = 8'h55;
    tick();
    RST_N = 0;
    tick();
    check("mid_rst_oe", DOUT_OE, 0);
    RST_N = 1; CS_N = 1; WR_N = 1;
    repeat (2) tick();
    access(0, 3'd4, 8'h00, 0, rd, lat);
    check("rd4_after_rst", rd, 8'h00);
    access(0, 3'd3, 8'h00, 0, rd, lat);
    check("rd3_after_rst", rd, 8'h00);
    check("port_after_rst", PORT_OUT, 8'h5A);

    for (int n = 0; n < 250; n++) begin
      int kind;
      kind = int'($urandom_range(0, 11));
      PORT_IN = 8'($urandom);
      if (kind == 10) begin
        CS_N = 0; RD_N = 0; WR_N = 0;
        repeat ($urandom_range(1, 3)) tick();
        CS_N = 1; RD_N = 1; WR_N = 1;
        tick();
      end else if (kind == 11) begin
        CS_N = 0; ADDR = 3'($urandom); DIN = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin WR_N = 0; RD_N = 1; end
        else begin WR_N = 1; RD_N = 0; end
        tick();
        if ($urandom_range(0, 1) == 1) CS_N = 1;
        else begin RD_N = 1; WR_N = 1; end
        tick();
        CS_N = 1; RD_N = 1; WR_N = 1;
        tick();
      end else begin
        access(kind < 5, 3'($urandom), 8'($urandom), int'($urandom_range(0, 2)), rd, lat);
        check("rand_latency", lat, 4);
        repeat ($urandom_range(0, 1)) tick();
      end
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
